// File: rtl/pwr_pkg.sv
// Shared types for the power-sequencing controller: reported power state,
// internal sequencer state and the mapping between them.
package pwr_pkg;

  typedef enum logic [1:0] {
    PS_ACTIVE    = 2'b00,
    PS_SAVING    = 2'b01,
    PS_DOWN      = 2'b10,
    PS_RESTORING = 2'b11
  } power_state_t;

  typedef enum logic [2:0] {
    S_ACTIVE  = 3'd0,
    S_ISO_ON  = 3'd1,
    S_SAVE    = 3'd2,
    S_OFF     = 3'd3,
    S_PWR_UP  = 3'd4,
    S_RESTORE = 3'd5
  } seq_state_t;

  function automatic power_state_t map_power_state(input seq_state_t s);
    case (s)
      S_ACTIVE:           return PS_ACTIVE;
      S_ISO_ON, S_SAVE:   return PS_SAVING;
      S_OFF:              return PS_DOWN;
      S_PWR_UP, S_RESTORE: return PS_RESTORING;
      default:            return PS_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable phase counter: holds the 1-based cycle index within the current
// sequencer state, saturating instead of wrapping, with a terminal-count flag.
module pwr_seq_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         done
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // next count: restart at 1 on state entry, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ONE;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == term);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-sequencing controller for one switchable domain: orders isolation,
// retention save/restore and the power-switch enable on sleep/wake requests.
module pwr_seq_ctrl
  import pwr_pkg::*;
#(
  parameter int ISO_SETUP      = 1,
  parameter int SAVE_CYCLES    = 1,
  parameter int PWR_UP_MIN     = 4,
  parameter int PG_TIMEOUT     = 64,
  parameter int RESTORE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       pwr_good,
  input  logic       err_clr,
  output logic       power_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic [1:0] power_state,
  output logic       busy,
  output logic       err_pg_timeout
);

  localparam int CW = $clog2(PG_TIMEOUT + 1);

  seq_state_t   state_d, state_q;
  logic         err_d, err_q;
  logic         timeout_s;
  logic         load_s;
  logic         done_s;
  logic [CW-1:0] term_s;
  logic [CW-1:0] cnt_s;

  logic         power_en_d, power_en_q;
  logic         iso_en_d, iso_en_q;
  logic         save_d, save_q;
  logic         restore_d, restore_q;
  power_state_t power_state_d, power_state_q;
  logic         busy_d, busy_q;
  logic         err_out_d, err_out_q;

  pwr_seq_timer #(.W(CW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .term (term_s),
    .cnt  (cnt_s),
    .done (done_s)
  );

  // next-state logic; requests are only acted on from ACTIVE or OFF
  always_comb begin
    state_d   = state_q;
    term_s    = {CW{1'b0}};
    timeout_s = 1'b0;
    case (state_q)
      S_ACTIVE: begin
        if (sleep_req) state_d = S_ISO_ON;
        else           state_d = S_ACTIVE;
      end
      S_ISO_ON: begin
        term_s = CW'(ISO_SETUP);
        if (done_s) state_d = S_SAVE;
        else        state_d = S_ISO_ON;
      end
      S_SAVE: begin
        term_s = CW'(SAVE_CYCLES);
        if (done_s) state_d = S_OFF;
        else        state_d = S_SAVE;
      end
      S_OFF: begin
        if (!sleep_req && !err_q) state_d = S_PWR_UP;
        else                      state_d = S_OFF;
      end
      S_PWR_UP: begin
        term_s = CW'(PG_TIMEOUT);
        if ((cnt_s >= CW'(PWR_UP_MIN)) && pwr_good) begin
          state_d = S_RESTORE;
        end else if (done_s) begin
          state_d   = S_OFF;
          timeout_s = 1'b1;
        end else begin
          state_d = S_PWR_UP;
        end
      end
      S_RESTORE: begin
        term_s = CW'(RESTORE_CYCLES);
        if (done_s) state_d = S_ACTIVE;
        else        state_d = S_RESTORE;
      end
      default: state_d = S_ACTIVE;
    endcase

    load_s = (state_d != state_q);

    // a timeout raised in the same cycle as err_clr takes precedence
    if (timeout_s)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // output decode from the current state, registered below
  always_comb begin
    power_en_d    = (state_q != S_OFF);
    iso_en_d      = (state_q != S_ACTIVE);
    save_d        = (state_q == S_SAVE);
    restore_d     = (state_q == S_RESTORE);
    power_state_d = map_power_state(state_q);
    busy_d        = (state_q == S_ISO_ON) || (state_q == S_SAVE) ||
                    (state_q == S_PWR_UP) || (state_q == S_RESTORE);
    err_out_d     = err_q;
  end

  // state, sticky error and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ACTIVE;
      err_q         <= 1'b0;
      power_en_q    <= 1'b1;
      iso_en_q      <= 1'b0;
      save_q        <= 1'b0;
      restore_q     <= 1'b0;
      power_state_q <= PS_ACTIVE;
      busy_q        <= 1'b0;
      err_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      power_en_q    <= power_en_d;
      iso_en_q      <= iso_en_d;
      save_q        <= save_d;
      restore_q     <= restore_d;
      power_state_q <= power_state_d;
      busy_q        <= busy_d;
      err_out_q     <= err_out_d;
    end
  end

  assign power_en       = power_en_q;
  assign iso_en         = iso_en_q;
  assign save           = save_q;
  assign restore        = restore_q;
  assign power_state    = power_state_q;
  assign busy           = busy_q;
  assign err_pg_timeout = err_out_q;

endmodule
